// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among
// NREQ byte producers over a four-phase tx_req/tx_req_ack link.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int ACK_TMO = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       cfg_comp,
    input  logic [1:0]        cfg_stop_sel,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_tr_en,
    output logic [15:0]       tx_comp,
    output logic [1:0]        tx_stop_sel,
    output logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_req_ack,
    output logic [2:0]        grant_id,
    output logic              busy,
    output logic              err_tmo,
    output logic              err_abort
);

    localparam logic [23:0] TMO = 24'(ACK_TMO);

    typedef enum logic [1:0] {
        IDLE_s,
        REQ_s,
        RELEASE_s
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [23:0]       cnt;
    logic [23:0]       cnt_n;
    logic [23:0]       cnt_inc;
    logic [NREQ-1:0]   ready_n;
    logic [15:0]       comp_n;
    logic [1:0]        stop_n;
    logic [7:0]        data_n;
    logic              req_n;
    logic [2:0]        gid_n;
    logic              tmo_n;
    logic              abort_n;

    logic              win_ok;
    logic [2:0]        win;
    logic [NREQ-1:0]   win_hot;
    logic [7:0]        win_byte;

    // Scan downward so the nearest valid requester after grant_id wins.
    always_comb begin : pick
        int unsigned idx;
        logic        hit;
        win_ok = 1'b0;
        win    = grant_id;
        idx    = 0;
        hit    = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (32'(grant_id) + 32'(k)) % 32'(NREQ);
            hit = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (idx == 32'(i) && req_valid[i]) begin
                    hit = 1'b1;
                end
            end
            if (hit) begin
                win_ok = 1'b1;
                win    = idx[2:0];
            end
        end
    end

    always_comb begin
        win_hot  = '0;
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 3'(i)) begin
                win_hot[i] = 1'b1;
                win_byte   = req_data[i*8 +: 8];
            end
        end
    end

    assign cnt_inc = cnt + 24'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ready_n = '0;
        comp_n  = tx_comp;
        stop_n  = tx_stop_sel;
        data_n  = tx_data;
        req_n   = tx_req;
        gid_n   = grant_id;
        tmo_n   = 1'b0;
        abort_n = 1'b0;
        if (!enable) begin
            state_n = IDLE_s;
            cnt_n   = '0;
            req_n   = 1'b0;
            abort_n = (state != IDLE_s);
        end else begin
            unique case (state)
                IDLE_s: begin
                    cnt_n = '0;
                    // Never start a grant while the last ack is still up.
                    if (win_ok && !tx_req_ack) begin
                        data_n  = win_byte;
                        comp_n  = cfg_comp;
                        stop_n  = cfg_stop_sel;
                        req_n   = 1'b1;
                        ready_n = win_hot;
                        gid_n   = win;
                        state_n = REQ_s;
                    end
                end
                REQ_s: begin
                    if (tx_req_ack) begin
                        req_n   = 1'b0;
                        cnt_n   = '0;
                        state_n = RELEASE_s;
                    end else if (cnt_inc == TMO) begin
                        req_n   = 1'b0;
                        cnt_n   = '0;
                        tmo_n   = 1'b1;
                        state_n = RELEASE_s;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                RELEASE_s: begin
                    if (!tx_req_ack) begin
                        state_n = IDLE_s;
                    end
                end
                default: begin
                    state_n = IDLE_s;
                    req_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE_s;
            cnt         <= '0;
            req_ready   <= '0;
            tx_tr_en    <= 1'b0;
            tx_comp     <= '0;
            tx_stop_sel <= '0;
            tx_data     <= '0;
            tx_req      <= 1'b0;
            grant_id    <= 3'(NREQ - 1);
            busy        <= 1'b0;
            err_tmo     <= 1'b0;
            err_abort   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            req_ready   <= ready_n;
            tx_tr_en    <= enable;
            tx_comp     <= comp_n;
            tx_stop_sel <= stop_n;
            tx_data     <= data_n;
            tx_req      <= req_n;
            grant_id    <= gid_n;
            busy        <= (state_n != IDLE_s);
            err_tmo     <= tmo_n;
            err_abort   <= abort_n;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among NREQ byte producers. It accepts bytes over per-requester valid/ready handshakes and drives the transmitter's `tx_data`/`tx_req`/`tx_req_ack` four-phase handshake. It also supplies the transmitter's `comp`, `stop_sel` and `tr_en` controls. It sits between the peripheral's byte sources (CPU register, debug stream, etc.) and the UART transmitter.

## Interface

**Parameters**
- `NREQ`, default 4: number of requesters (2..8).
- `ACK_TMO`, default 65535: maximum cycles spent in `REQ_s` waiting for `tx_req_ack` rise (1..2^24-1).

**Ports**
- `clk`  in  1  clock. One clock domain.
- `reset`  in  1  reset, synchronous and active-high.
- `enable`  in  1  global enable.
- `cfg_comp`  in  16  baud compare value, latched at grant.
- `cfg_stop_sel`  in  2  stop-bit select, latched at grant.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  NREQ*8  requester i byte on bits [8i+7:8i].
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse.
- `tx_tr_en`  out  1  to transmitter `tr_en`.
- `tx_comp`  out  16  to transmitter `comp`.
- `tx_stop_sel`  out  2  to transmitter `stop_sel`.
- `tx_data`  out  8  to transmitter `tx_data`.
- `tx_req`  out  1  to transmitter `tx_req`.
- `tx_req_ack`  in  1  from transmitter.
- `grant_id`  out  3  index of the current or last granted requester.
- `busy`  out  1  high when state != `IDLE_s`.
- `err_tmo`  out  1  one-cycle pulse on ack timeout.
- `err_abort`  out  1  one-cycle pulse when `enable` drops mid-transfer.

## Operation

- All outputs are registered.
- Reset values:
  - `req_ready`=0, `tx_tr_en`=0, `tx_comp`=0, `tx_stop_sel`=0, `tx_data`=0, `tx_req`=0.
  - `grant_id`=NREQ-1, `busy`=0, `err_tmo`=0, `err_abort`=0.
  - State = `IDLE_s`, timeout counter = 0.
- `tx_tr_en` is `enable` delayed by one register.

**States**
- `IDLE_s`
  - Condition: `enable`=1 and any `req_valid`.
  - Select winner g: first set bit of `req_valid` searching from (`grant_id`+1) mod NREQ upward with wrap.
  - Registered actions: `tx_data`<=byte g, `tx_comp`<=`cfg_comp`, `tx_stop_sel`<=`cfg_stop_sel`, `tx_req`<=1, `req_ready[g]`<=1, `grant_id`<=g.
  - Go to `REQ_s`.
- `REQ_s`
  - `req_ready` returns to 0 after one cycle. The counter increments each cycle.
  - `tx_req_ack`=1: `tx_req`<=0, clear counter, go to `RELEASE_s`.
  - Counter reaches ACK_TMO: `tx_req`<=0, pulse `err_tmo`, go to `RELEASE_s`.
- `RELEASE_s`
  - `tx_req_ack`=0: go to `IDLE_s`.
- Boundary: if ack rises on the same cycle the counter reaches ACK_TMO, ack wins and there is no `err_tmo`.

**Rules**
- `enable`=0 in any state: next state `IDLE_s`, `tx_req`<=0, `req_ready`<=0.
  - `err_abort` pulses if the state was `REQ_s` or `RELEASE_s`.
  - `grant_id` is held. An accepted byte is dropped.
- A requester holds `req_valid` and its byte stable until it sees `req_ready`. The byte is consumed in the `req_ready` cycle.
- `tx_data`, `tx_comp` and `tx_stop_sel` stay constant from the grant until the next grant.
- The arbiter starts no new grant while `tx_req_ack`=1.
- Dropping `req_valid` without a ready has no effect.
- A requester that is not valid is skipped. There is no starvation: after a grant to g, every other valid requester is served before g again.
- `grant_id` arithmetic is mod NREQ and wraps from NREQ-1 to 0.

## Timing

- Grant latency: `req_valid` seen at edge N in `IDLE_s` gives `tx_req`=1 and `req_ready[g]`=1 during cycle N+1.
- `tx_req` falls one cycle after `tx_req_ack` is sampled high.
- Return to `IDLE_s` occurs one cycle after `tx_req_ack` is sampled low. The next grant decision is made on that following edge.
- Minimum per-byte overhead is 3 cycles plus the transmitter frame time.
- Timeout: `tx_req` falls exactly ACK_TMO cycles after entering `REQ_s`.
- `err_tmo` and `err_abort` are high for exactly one cycle.
- Reset is honoured on any edge and overrides `enable`.

## Test plan

- **Single requester:** after reset, `enable`=1, `req_valid`=4'b0001, byte 0x55 with transmitter model.
  - `req_ready`=0001 for 1 cycle, `tx_data`=0x55, one frame 0x55 on the line.
  - Back to `IDLE_s` 1 cycle after ack falls.
- **Round-robin:** all four requesters valid continuously with bytes 0xA0..0xA3.
  - Grant order 0,1,2,3,0 and frames in that order.
  - `grant_id` wraps from 3 to 0.
- **Skip and priority:** after grant 1, `req_valid`=4'b0011.
  - Next grant is 0 (wrap from 2), then 1.
- **Config latch:** `cfg_comp`=0x0010 at grant, then changed to 0x0020 mid-frame.
  - `tx_comp` stays 0x0010 until the next grant.
- **Ack timeout:** ACK_TMO=8, model never acks.
  - `tx_req` high 8 cycles then 0, one `err_tmo` pulse, back to `IDLE_s` (ack low).
- **Abort:** `enable` dropped in `REQ_s`.
  - Next cycle `IDLE_s`, `tx_req`=0, `err_abort` pulse, `tx_tr_en`=0.
  - No grant while `enable`=0. After re-enable, the next grant goes to the next requester after the aborted one.
